// File: rtl/wb_bus_monitor.sv
// Passive Wishbone B4 pipelined-link monitor: tracks outstanding requests,
// flags protocol violations and timeouts as sticky bits, and counts events.
module wb_bus_monitor #(
  parameter int DataWidth      = 32,
  parameter int AddrWidth      = 30,
  parameter int MaxOutstanding = 4,
  parameter int TimeoutCycles  = 256,
  parameter int CountWidth     = 16,
  localparam int SelWidth      = DataWidth / 8,
  localparam int OutW          = $clog2(MaxOutstanding + 1) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  wb_cyc_o,
  input  logic                  wb_stb_o,
  input  logic                  wb_we_o,
  input  logic [AddrWidth-1:0]  wb_addr_o,
  input  logic [DataWidth-1:0]  wb_data_o,
  input  logic [SelWidth-1:0]   wb_sel_o,
  input  logic [DataWidth-1:0]  wb_data_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_stall_i,
  output logic [7:0]            violation_o,
  output logic                  violation_any_o,
  output logic [2:0]            first_violation_o,
  output logic [OutW-1:0]       outstanding_o,
  output logic [CountWidth-1:0] req_count_o,
  output logic [CountWidth-1:0] ack_count_o,
  output logic [CountWidth-1:0] err_count_o
);

  localparam int IdleW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TimeoutCycles - 1);
  localparam logic [OutW-1:0]  OutMax  = '1;
  localparam logic [OutW-1:0]  OutLim  = OutW'(MaxOutstanding);

  function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] c,
                                                    input logic en);
    return (en && (c != '1)) ? c + 1'b1 : c;
  endfunction

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  logic                  w_acc;
  logic                  w_rsp;
  logic [OutW-1:0]       w_out_nxt;
  logic [IdleW-1:0]      w_idle_nxt;
  logic [7:0]            w_ev;
  logic                  w_unused_rdata;

  logic [OutW-1:0]       r_out;
  logic [IdleW-1:0]      r_idle;
  logic [7:0]            r_viol;
  logic [2:0]            r_first;
  logic [CountWidth-1:0] r_req;
  logic [CountWidth-1:0] r_ack;
  logic [CountWidth-1:0] r_err;

  logic                  r_snap_vld;
  logic                  r_p_cyc;
  logic                  r_p_stb;
  logic                  r_p_stall;
  logic                  r_p_we;
  logic [AddrWidth-1:0]  r_p_addr;
  logic [SelWidth-1:0]   r_p_sel;
  logic [DataWidth-1:0]  r_p_data;

  assign w_unused_rdata = ^wb_data_i;

  assign w_acc = wb_cyc_o & wb_stb_o & ~wb_stall_i;
  assign w_rsp = wb_cyc_o & (wb_ack_i | wb_err_i);

  always_comb begin
    w_out_nxt = r_out;
    if (!wb_cyc_o)                                 w_out_nxt = '0;
    else if (w_acc && !w_rsp && (r_out != OutMax)) w_out_nxt = r_out + 1'b1;
    else if (!w_acc && w_rsp && (r_out != '0))     w_out_nxt = r_out - 1'b1;
  end

  always_comb begin
    w_idle_nxt = r_idle;
    if ((r_out == '0) || w_rsp || !wb_cyc_o) w_idle_nxt = '0;
    else if (r_idle != IdleMax)              w_idle_nxt = r_idle + 1'b1;
  end

  // Stall rule compares this cycle against the snapshot of a stalled request.
  always_comb begin
    w_ev    = '0;
    w_ev[0] = wb_stb_o & ~wb_cyc_o;
    w_ev[1] = wb_stb_o & wb_we_o & (wb_sel_o == '0);
    w_ev[2] = wb_ack_i & wb_err_i;
    w_ev[3] = r_snap_vld & r_p_cyc & r_p_stb & r_p_stall & wb_cyc_o &
              (~wb_stb_o | (wb_addr_o != r_p_addr) | (wb_we_o != r_p_we) |
               (wb_sel_o != r_p_sel) | (wb_we_o & (wb_data_o != r_p_data)));
    w_ev[4] = (wb_ack_i | wb_err_i) & (r_out == '0);
    w_ev[5] = ~wb_cyc_o & (r_out != '0);
    w_ev[6] = (w_out_nxt > OutLim);
    w_ev[7] = (r_idle == IdleMax);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out      <= '0;
      r_idle     <= '0;
      r_snap_vld <= 1'b0;
      r_p_cyc    <= 1'b0;
      r_p_stb    <= 1'b0;
      r_p_stall  <= 1'b0;
      r_p_we     <= 1'b0;
      r_p_addr   <= '0;
      r_p_sel    <= '0;
      r_p_data   <= '0;
    end else begin
      r_out      <= w_out_nxt;
      r_idle     <= w_idle_nxt;
      r_snap_vld <= 1'b1;
      r_p_cyc    <= wb_cyc_o;
      r_p_stb    <= wb_stb_o;
      r_p_stall  <= wb_stall_i;
      r_p_we     <= wb_we_o;
      r_p_addr   <= wb_addr_o;
      r_p_sel    <= wb_sel_o;
      r_p_data   <= wb_data_o;
    end
  end

  // Clear wins over any event in the same cycle; bus-tracking state above is untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_viol  <= '0;
      r_first <= '0;
      r_req   <= '0;
      r_ack   <= '0;
      r_err   <= '0;
    end else if (clear_i) begin
      r_viol  <= '0;
      r_first <= '0;
      r_req   <= '0;
      r_ack   <= '0;
      r_err   <= '0;
    end else begin
      if ((r_viol == '0) && (w_ev != '0)) r_first <= lowest_set(w_ev);
      r_viol <= r_viol | w_ev;
      r_req  <= sat_inc(r_req, w_acc);
      r_ack  <= sat_inc(r_ack, wb_cyc_o & wb_ack_i);
      r_err  <= sat_inc(r_err, wb_cyc_o & wb_err_i);
    end
  end

  assign violation_o       = r_viol;
  assign violation_any_o   = |r_viol;
  assign first_violation_o = r_first;
  assign outstanding_o     = r_out;
  assign req_count_o       = r_req;
  assign ack_count_o       = r_ack;
  assign err_count_o       = r_err;

endmodule

// File: tb/tb_wb_bus_monitor.sv
// Self-checking bench for wb_bus_monitor: vector table, directed corner
// sequences and randomized traffic against a behavioural reference model.
module tb_wb_bus_monitor;

  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int SW   = DW / 8;
  localparam int MAXO = 4;
  localparam int TO   = 8;
  localparam int CW   = 6;
  localparam int OUTW = $clog2(MAXO + 1) + 1;
  localparam int OUT_MAX = (1 << OUTW) - 1;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          clr;
  logic          cyc, stb, we, ack, err, stall;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] sel;

  logic [7:0]      violation;
  logic            violation_any;
  logic [2:0]      first_violation;
  logic [OUTW-1:0] outstanding;
  logic [CW-1:0]   req_count, ack_count, err_count;

  int n_checks = 0;
  int n_errors = 0;

  wb_bus_monitor #(
    .DataWidth(DW), .AddrWidth(AW), .MaxOutstanding(MAXO),
    .TimeoutCycles(TO), .CountWidth(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clr),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we),
    .wb_addr_o(addr), .wb_data_o(wdata), .wb_sel_o(sel),
    .wb_data_i(rdata), .wb_ack_i(ack), .wb_err_i(err), .wb_stall_i(stall),
    .violation_o(violation), .violation_any_o(violation_any),
    .first_violation_o(first_violation), .outstanding_o(outstanding),
    .req_count_o(req_count), .ack_count_o(ack_count), .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  // Reference model state (plain integers, rules applied directly)
  int         m_out, m_idle, m_first, m_req, m_ack, m_err;
  bit [7:0]   m_viol;
  bit         p_vld, p_cyc, p_stb, p_stall, p_we;
  bit [AW-1:0] p_addr;
  bit [SW-1:0] p_sel;
  bit [DW-1:0] p_data;

  task automatic model_reset();
    m_out = 0; m_idle = 0; m_first = 0; m_req = 0; m_ack = 0; m_err = 0;
    m_viol = '0;
    p_vld = 0; p_cyc = 0; p_stb = 0; p_stall = 0; p_we = 0;
    p_addr = '0; p_sel = '0; p_data = '0;
  endtask

  task automatic model_edge();
    bit acc, rsp, found;
    bit [7:0] ev;
    int nout;
    acc = cyc && stb && !stall;
    rsp = cyc && (ack || err);
    nout = cyc ? m_out + int'(acc) - int'(rsp) : 0;
    if (nout < 0) nout = 0;
    if (nout > OUT_MAX) nout = OUT_MAX;
    ev = '0;
    ev[0] = stb && !cyc;
    ev[1] = stb && we && (sel == 0);
    ev[2] = ack && err;
    ev[3] = p_vld && p_cyc && p_stb && p_stall && cyc &&
            (!stb || addr != p_addr || we != p_we || sel != p_sel || (we && wdata != p_data));
    ev[4] = (ack || err) && (m_out == 0);
    ev[5] = !cyc && (m_out > 0);
    ev[6] = nout > MAXO;
    ev[7] = (m_idle == TO - 1);
    if (clr) begin
      m_viol = '0; m_first = 0; m_req = 0; m_ack = 0; m_err = 0;
    end else begin
      if (m_viol == 0 && ev != 0) begin
        found = 0;
        for (int i = 0; i < 8; i++)
          if (ev[i] && !found) begin m_first = i; found = 1; end
      end
      m_viol |= ev;
      if (acc && m_req < CNT_MAX) m_req++;
      if (cyc && ack && m_ack < CNT_MAX) m_ack++;
      if (cyc && err && m_err < CNT_MAX) m_err++;
    end
    if (m_out == 0 || rsp || !cyc) m_idle = 0;
    else if (m_idle < TO - 1) m_idle++;
    m_out = nout;
    p_vld = 1; p_cyc = cyc; p_stb = stb; p_stall = stall; p_we = we;
    p_addr = addr; p_sel = sel; p_data = wdata;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " violation"}, 64'(violation), 64'(m_viol));
    chk({tag, " any"}, 64'(violation_any), 64'(m_viol != 0));
    chk({tag, " first"}, 64'(first_violation), 64'(m_first));
    chk({tag, " outstanding"}, 64'(outstanding), 64'(m_out));
    chk({tag, " req_count"}, 64'(req_count), 64'(m_req));
    chk({tag, " ack_count"}, 64'(ack_count), 64'(m_ack));
    chk({tag, " err_count"}, 64'(err_count), 64'(m_err));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " violation"}, 64'(violation), 64'd0);
    chk({tag, " any"}, 64'(violation_any), 64'd0);
    chk({tag, " first"}, 64'(first_violation), 64'd0);
    chk({tag, " outstanding"}, 64'(outstanding), 64'd0);
    chk({tag, " req_count"}, 64'(req_count), 64'd0);
    chk({tag, " ack_count"}, 64'(ack_count), 64'd0);
    chk({tag, " err_count"}, 64'(err_count), 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_ni) model_edge();
    #1;
  endtask

  task automatic bus(input logic c, input logic s, input logic w, input logic a,
                     input logic e, input logic st, input logic cl,
                     input logic [AW-1:0] ad, input logic [SW-1:0] se);
    cyc = c; stb = s; we = w; ack = a; err = e; stall = st; clr = cl;
    addr = ad; sel = se;
  endtask

  task automatic idle_clear();
    bus(0, 0, 0, 0, 0, 0, 1, 8'h00, 2'b11); step();
    bus(0, 0, 0, 0, 0, 0, 0, 8'h00, 2'b11);
  endtask

  typedef struct packed {
    logic cyc, stb, we, ack, err, stall, clr;
    logic [SW-1:0] sel;
    logic [7:0]    exp_viol;
    logic [2:0]    exp_first;
    logic [OUTW-1:0] exp_out;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic [6:0] ctl, input logic [SW-1:0] s,
                              input logic [7:0] v, input logic [2:0] f,
                              input logic [OUTW-1:0] o);
    vec_t r;
    {r.cyc, r.stb, r.we, r.ack, r.err, r.stall, r.clr} = ctl;
    r.sel = s; r.exp_viol = v; r.exp_first = f; r.exp_out = o;
    return r;
  endfunction

  initial begin
    bit hold;
    // ctl bits: cyc stb we ack err stall clr
    tbl[0]  = mk(7'b0000000, 2'b11, 8'h00, 3'd0, 4'd0);
    tbl[1]  = mk(7'b1100000, 2'b11, 8'h00, 3'd0, 4'd1);
    tbl[2]  = mk(7'b1000000, 2'b11, 8'h00, 3'd0, 4'd1);
    tbl[3]  = mk(7'b1001000, 2'b11, 8'h00, 3'd0, 4'd0);
    tbl[4]  = mk(7'b0000000, 2'b11, 8'h00, 3'd0, 4'd0);
    tbl[5]  = mk(7'b0100000, 2'b11, 8'h01, 3'd0, 4'd0);
    tbl[6]  = mk(7'b0100001, 2'b11, 8'h00, 3'd0, 4'd0);
    tbl[7]  = mk(7'b1110000, 2'b00, 8'h02, 3'd1, 4'd1);
    tbl[8]  = mk(7'b1001100, 2'b11, 8'h06, 3'd1, 4'd0);
    tbl[9]  = mk(7'b0000001, 2'b11, 8'h00, 3'd0, 4'd0);
    tbl[10] = mk(7'b1001000, 2'b11, 8'h10, 3'd4, 4'd0);
    tbl[11] = mk(7'b1000001, 2'b11, 8'h00, 3'd0, 4'd0);
    tbl[12] = mk(7'b1100000, 2'b11, 8'h00, 3'd0, 4'd1);
    tbl[13] = mk(7'b0000000, 2'b11, 8'h20, 3'd5, 4'd0);
    tbl[14] = mk(7'b0000001, 2'b11, 8'h00, 3'd0, 4'd0);

    rst_ni = 0; wdata = '0; rdata = '0;
    bus(0, 0, 0, 0, 0, 0, 0, 8'h00, 2'b11);
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    #3 rst_ni = 1;
    step(); step();

    for (int i = 0; i < 15; i++) begin
      bus(tbl[i].cyc, tbl[i].stb, tbl[i].we, tbl[i].ack, tbl[i].err, tbl[i].stall,
          tbl[i].clr, 8'h10, tbl[i].sel);
      step();
      chk($sformatf("tbl%0d violation", i), 64'(violation), 64'(tbl[i].exp_viol));
      chk($sformatf("tbl%0d first", i), 64'(first_violation), 64'(tbl[i].exp_first));
      chk($sformatf("tbl%0d outstanding", i), 64'(outstanding), 64'(tbl[i].exp_out));
    end

    // Single read: accept, one gap cycle, ack
    bus(1, 1, 0, 0, 0, 0, 0, 8'h04, 2'b11); step();
    chk("read out1", 64'(outstanding), 64'd1);
    bus(1, 0, 0, 0, 0, 0, 0, 8'h04, 2'b11); step();
    chk("read out1b", 64'(outstanding), 64'd1);
    bus(1, 0, 0, 1, 0, 0, 0, 8'h04, 2'b11); step();
    chk("read out0", 64'(outstanding), 64'd0);
    chk("read req", 64'(req_count), 64'd1);
    chk("read ack", 64'(ack_count), 64'd1);
    chk("read viol", 64'(violation), 64'd0);
    idle_clear();

    // Stalled write, address changed while still stalled
    wdata = 16'hA5A5;
    for (int k = 0; k < 3; k++) begin
      bus(1, 1, 1, 0, 0, 1, 0, 8'h10, 2'b11); step();
      chk($sformatf("stall hold%0d", k), 64'(violation), 64'd0);
    end
    bus(1, 1, 1, 0, 0, 1, 0, 8'h14, 2'b11); step();
    chk("stall viol", 64'(violation), 64'h08);
    chk("stall first", 64'(first_violation), 64'd3);
    idle_clear();

    // Pipelining beyond the outstanding limit
    for (int k = 1; k <= 5; k++) begin
      bus(1, 1, 0, 0, 0, 0, 0, 8'(k), 2'b11); step();
    end
    chk("pipe out", 64'(outstanding), 64'd5);
    chk("pipe viol", 64'(violation), 64'h40);
    chk("pipe first", 64'(first_violation), 64'd6);
    idle_clear();

    // Timeout: one request, no response
    bus(1, 1, 0, 0, 0, 0, 0, 8'h30, 2'b11); step();
    for (int k = 1; k <= 7; k++) begin
      bus(1, 0, 0, 0, 0, 0, 0, 8'h30, 2'b11); step();
      chk($sformatf("tmo early%0d", k), 64'(violation[7]), 64'd0);
    end
    step();
    chk("tmo viol", 64'(violation), 64'h80);
    chk("tmo first", 64'(first_violation), 64'd7);
    repeat (3) step();
    chk("tmo hold viol", 64'(violation), 64'h80);
    chk("tmo hold out", 64'(outstanding), 64'd1);
    idle_clear();

    // ack and err together with nothing outstanding, then clear
    bus(1, 0, 0, 1, 1, 0, 0, 8'h00, 2'b11); step();
    chk("dual viol", 64'(violation), 64'h14);
    chk("dual first", 64'(first_violation), 64'd2);
    chk("dual errcnt", 64'(err_count), 64'd1);
    bus(1, 0, 0, 0, 0, 0, 1, 8'h00, 2'b11); step();
    chk_all_zero("dual clear");
    bus(0, 0, 0, 0, 0, 0, 0, 8'h00, 2'b11); step();

    // Async reset pulsed mid-burst
    for (int k = 0; k < 3; k++) begin
      bus(1, 1, 0, 0, 0, 0, 0, 8'(k), 2'b11); step();
    end
    chk("burst out", 64'(outstanding), 64'd3);
    #3 rst_ni = 0;
    model_reset();
    #1 chk_all_zero("async reset");
    bus(1, 1, 0, 0, 0, 1, 0, 8'h20, 2'b11);
    @(posedge clk);
    #4 rst_ni = 1;
    bus(1, 1, 0, 0, 0, 1, 0, 8'h24, 2'b11); step();
    chk("post rst viol", 64'(violation), 64'd0);
    chk("post rst out", 64'(outstanding), 64'd0);
    step();
    chk("post rst hold", 64'(violation), 64'd0);
    bus(1, 1, 0, 0, 0, 1, 0, 8'h28, 2'b11); step();
    chk("post rst stall", 64'(violation), 64'h08);
    idle_clear();

    // Randomized traffic against the reference model
    for (int n = 0; n < 2000; n++) begin
      hold = cyc && stb && stall && ($urandom_range(0, 9) < 8);
      if (!hold) begin
        cyc   = ($urandom_range(0, 19) != 0);
        stb   = $urandom_range(0, 1);
        we    = $urandom_range(0, 1);
        addr  = 8'($urandom_range(0, 3));
        sel   = 2'($urandom_range(0, 3));
        wdata = 16'($urandom_range(0, 3));
      end
      stall = ($urandom_range(0, 3) == 0);
      ack   = ($urandom_range(0, 3) == 0);
      err   = ($urandom_range(0, 19) == 0);
      clr   = ($urandom_range(0, 199) == 0);
      rdata = 16'($urandom);
      step();
      chk_model($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
